// File: rtl/temp_pkg.sv
// Shared types for the thermistor voltage/temperature blocks.
//   VCODE_W      : thermistor voltage code width
//   TEMP_W       : signed temperature width
//   t2v_state_e  : temp_to_vcode controller states
//   vcode_t      : voltage code
//   temp_t       : signed temperature
package temp_pkg;

  localparam int unsigned VCODE_W = 4;
  localparam int unsigned TEMP_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    RESP
  } t2v_state_e;

  typedef logic        [VCODE_W-1:0] vcode_t;
  typedef logic signed [TEMP_W-1:0]  temp_t;

endpackage

// File: rtl/voltage.sv
// Thermistor voltage block: maps a 4-bit voltage code to the temperature it
// represents (signed, tenths of a degree). Purely combinational. The
// temperature rises strictly with the code.
//   v_therm    in   VCODE_W  voltage code
//   temp_therm out  TEMP_W   temperature for that code, signed
module voltage
  import temp_pkg::*;
(
  input  vcode_t v_therm,
  output temp_t  temp_therm
);

  localparam temp_t TEMP_LUT [16] = '{
    -400, -250, -120,  -10,
      85,  170,  250,  325,
     395,  460,  520,  575,
     625,  670,  710,  745
  };

  assign temp_therm = TEMP_LUT[v_therm];

endmodule

// File: rtl/temp_to_vcode.sv
// Inverse of the voltage block: given a target temperature, finds the voltage
// code that produces it with a VCODE_W-step successive-approximation search,
// using the voltage block as the forward model.
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   req_valid  in   1        target temperature offered
//   req_ready  out  1        idle, able to accept a request
//   req_temp   in   TEMP_W   target temperature, signed
//   rsp_valid  out  1        result available, held until taken
//   rsp_ready  in   1        consumer takes result
//   rsp_code   out  VCODE_W  resolved voltage code
//   rsp_under  out  1        no code satisfies the compare (code 0)
//   rsp_over   out  1        target strictly beyond temp(all-ones)
module temp_to_vcode #(
  parameter int unsigned VCODE_W    = 4,
  parameter int unsigned TEMP_W     = 32,
  parameter bit          DESCENDING = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [TEMP_W-1:0]  req_temp,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [VCODE_W-1:0] rsp_code,
  output logic               rsp_under,
  output logic               rsp_over
);

  import temp_pkg::t2v_state_e;
  import temp_pkg::IDLE;
  import temp_pkg::SEARCH;
  import temp_pkg::RESP;

  localparam int unsigned BIT_W = (VCODE_W > 1) ? $clog2(VCODE_W) : 1;

  t2v_state_e                state_q, state_d;
  logic [VCODE_W-1:0]        acc_q, acc_d, acc_res, trial;
  logic [BIT_W-1:0]          idx_q, idx_d;
  logic signed [TEMP_W-1:0]  target_q, target_d;
  logic [VCODE_W-1:0]        code_q, code_d;
  logic                      under_q, under_d, over_q, over_d;

  logic signed [TEMP_W-1:0]  temp_trial, temp_min, temp_max;
  logic                      pass_trial, fail_min, beyond_max;

  // Main search path plus two constant-code instances for the range-end
  // flags; the constant ones reduce to fixed values in synthesis.
  voltage u_fwd     (.v_therm(trial), .temp_therm(temp_trial));
  voltage u_fwd_min (.v_therm('0),    .temp_therm(temp_min));
  voltage u_fwd_max (.v_therm('1),    .temp_therm(temp_max));

  always_comb begin
    trial      = acc_q | (VCODE_W'(1) << idx_q);
    pass_trial = DESCENDING ? (temp_trial >= target_q) : (temp_trial <= target_q);
    fail_min   = DESCENDING ? (temp_min   <  target_q) : (temp_min   >  target_q);
    beyond_max = DESCENDING ? (target_q   <  temp_max) : (target_q   >  temp_max);
    acc_res    = pass_trial ? trial : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    target_d = target_q;
    code_d   = code_q;
    under_d  = under_q;
    over_d   = over_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          target_d = $signed(req_temp);
          acc_d    = '0;
          idx_d    = BIT_W'(VCODE_W - 1);
          state_d  = SEARCH;
        end
      end
      SEARCH: begin
        acc_d = acc_res;
        if (idx_q == '0) begin
          // Result and range flags are registered on the same edge that
          // enters RESP, so they are valid together with rsp_valid.
          code_d  = acc_res;
          under_d = (acc_res == '0) && fail_min;
          over_d  = (acc_res == '1) && beyond_max;
          state_d = RESP;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      idx_q    <= BIT_W'(VCODE_W - 1);
      target_q <= '0;
      code_q   <= '0;
      under_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      target_q <= target_d;
      code_q   <= code_d;
      under_q  <= under_d;
      over_q   <= over_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_code  = code_q;
  assign rsp_under = under_q;
  assign rsp_over  = over_q;

endmodule

// File: tb/tb_temp_to_vcode.sv
module tb_temp_to_vcode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_temp;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_code;
  logic        rsp_under;
  logic        rsp_over;

  logic [3:0]  probe_code;
  logic [31:0] probe_temp;

  always #5 clk = ~clk;

  temp_to_vcode #(
    .VCODE_W   (4),
    .TEMP_W    (32),
    .DESCENDING(1'b0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_temp (req_temp),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_code (rsp_code),
    .rsp_under(rsp_under),
    .rsp_over (rsp_over)
  );

  voltage u_probe (.v_therm(probe_code), .temp_therm(probe_temp));

  // Documented characteristic of the voltage block.
  int tv [16] = '{-400, -250, -120, -10, 85, 170, 250, 325,
                  395, 460, 520, 575, 625, 670, 710, 745};

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    int temp;
    int code;
    bit under;
    bit over;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: largest code whose temperature does not exceed the target.
  task automatic ref_model(input int target, output int code, output bit under, output bit over);
    bit found = 0;
    code = 0;
    for (int c = 0; c < 16; c++) begin
      if (tv[c] <= target) begin
        code  = c;
        found = 1;
      end
    end
    under = !found;
    over  = target > tv[15];
  endtask

  task automatic transact(input int target, output int code, output bit under,
                          output bit over, output int lat);
    @(negedge clk);
    check("req_ready before request", req_ready, 1);
    req_valid = 1'b1;
    req_temp  = target;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    code  = rsp_code;
    under = rsp_under;
    over  = rsp_over;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid after take", rsp_valid, 0);
    check("req_ready after take", req_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  code, lat, got, k, cyc, last;
    bit  under, over, saw;
    int  tgt [100];
    int  exp_code[$];
    bit  exp_under[$], exp_over[$];

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_temp   = '0;
    rsp_ready  = 1'b0;
    probe_code = '0;

    // Forward model against its documented characteristic.
    for (int c = 0; c < 16; c++) begin
      probe_code = 4'(c);
      #1;
      check($sformatf("voltage[%0d]", c), $signed(probe_temp), tv[c]);
    end

    // Reset state.
    check("reset req_ready", req_ready, 1);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_code",  rsp_code, 0);
    check("reset rsp_under", rsp_under, 0);
    check("reset rsp_over",  rsp_over, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table: exact hits, between points, range ends.
    for (int c = 0; c < 16; c++) vecs.push_back('{tv[c], c, 1'b0, 1'b0});
    vecs.push_back('{tv[9] + 1,  9, 1'b0, 1'b0});
    vecs.push_back('{tv[10] - 1, 9, 1'b0, 1'b0});
    vecs.push_back('{tv[0] - 1,  0, 1'b1, 1'b0});
    vecs.push_back('{tv[15] + 1, 15, 1'b0, 1'b1});
    vecs.push_back('{int'(32'h8000_0000), 0, 1'b1, 1'b0});
    vecs.push_back('{int'(32'h7fff_ffff), 15, 1'b0, 1'b1});

    foreach (vecs[i]) begin
      transact(vecs[i].temp, code, under, over, lat);
      check($sformatf("vec%0d code", i),    code,  vecs[i].code);
      check($sformatf("vec%0d under", i),   under, vecs[i].under);
      check($sformatf("vec%0d over", i),    over,  vecs[i].over);
      check($sformatf("vec%0d latency", i), lat,   4);
    end

    // Backpressure with an ignored second request.
    @(negedge clk);
    req_valid = 1'b1;
    req_temp  = tv[3] + 5;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp latency", lat, 4);
    for (int i = 0; i < 10; i++) begin
      check("bp rsp_valid held", rsp_valid, 1);
      check("bp rsp_code held",  rsp_code, 3);
      check("bp req_ready low",  req_ready, 0);
      if (i == 4) begin
        req_valid = 1'b1;
        req_temp  = tv[14];
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp rsp_valid after take", rsp_valid, 0);
    check("bp req_ready after take", req_ready, 1);
    repeat (6) begin
      @(negedge clk);
      check("bp ignored request stays idle", rsp_valid | !req_ready, 0);
    end

    // Reset during the second search cycle.
    @(negedge clk);
    req_valid = 1'b1;
    req_temp  = tv[7];
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst req_ready", req_ready, 1);
    check("midrst rsp_valid", rsp_valid, 0);
    check("midrst rsp_code",  rsp_code, 0);
    check("midrst rsp_under", rsp_under, 0);
    check("midrst rsp_over",  rsp_over, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    check("midrst no replay", saw, 0);
    transact(tv[12], code, under, over, lat);
    check("post-reset code",    code, 12);
    check("post-reset latency", lat, 4);

    // Back-to-back random targets against the reference model.
    for (int i = 0; i < 100; i++) begin
      if (i % 4 == 0) tgt[i] = int'($urandom);
      else            tgt[i] = tv[0] - 60 + int'($urandom_range(0, 900));
    end
    k    = 0;
    got  = 0;
    cyc  = 0;
    last = -1;
    rsp_ready = 1'b1;
    while (got < 100 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        if (exp_code.size() == 0) begin
          check("b2b unexpected result", 1, 0);
        end else begin
          check($sformatf("b2b%0d code", got),  rsp_code,  exp_code.pop_front());
          check($sformatf("b2b%0d under", got), rsp_under, exp_under.pop_front());
          check($sformatf("b2b%0d over", got),  rsp_over,  exp_over.pop_front());
        end
        if (last >= 0) check($sformatf("b2b%0d spacing", got), cyc - last, 6);
        last = cyc;
        got++;
      end
      if (req_ready) begin
        if (k < 100) begin
          req_valid = 1'b1;
          req_temp  = tgt[k];
          ref_model(tgt[k], code, under, over);
          exp_code.push_back(code);
          exp_under.push_back(under);
          exp_over.push_back(over);
          k++;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("b2b result count", got, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
